// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

`default_nettype wire

// File: rtl/redirect_arb.sv
// ============================================================================
// Module   : redirect_arb
// Brief    : Priority select between trap and jump redirects (trap wins).
// Revision : 1.0
// ============================================================================
`default_nettype none

module redirect_arb
    import fetch_pkg::*;
(
    input  logic        trap_en_i,
    input  logic [31:0] trap_addr_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        redirect_en,
    output logic [31:0] redirect_addr
);

    always_comb begin
        redirect_en   = trap_en_i | jump_en_i;
        redirect_addr = trap_en_i ? word_align(trap_addr_i) : word_align(jump_addr_i);
    end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding instruction fetch FSM with trap/jump redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_en_i,
    input  logic [31:0] trap_addr_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;

    logic         redirect_en;
    logic [31:0]  redirect_addr;

    redirect_arb u_redirect_arb (
        .trap_en_i     (trap_en_i),
        .trap_addr_i   (trap_addr_i),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            inst_q     <= 32'h0;
            inst_pc_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (redirect_en) pc_d = redirect_addr;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt_i) begin
                    fetch_pc_d = pc_q;
                    pc_d       = redirect_en ? redirect_addr : pc_q + PC_STEP;
                    // A redirect racing the grant poisons the in-flight response.
                    kill_d     = redirect_en;
                    state_d    = ST_WAIT;
                end else if (redirect_en) begin
                    pc_d = redirect_addr;
                end
            end
            ST_WAIT: begin
                if (redirect_en) pc_d = redirect_addr;
                if (imem_rvalid_i) begin
                    if (kill_q || redirect_en) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_d    = imem_rdata_i;
                        inst_pc_d = fetch_pc_q;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect_en) begin
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_en) begin
                    pc_d    = redirect_addr;
                    state_d = ST_REQ;
                end else if (inst_ready_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req_o   = (state_q == ST_REQ);
    assign imem_addr_o  = pc_q;
    assign inst_valid_o = (state_q == ST_HOLD);
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

endmodule

`default_nettype wire
